// File: rtl/disp_pkg.sv
// disp_pkg: shared display constants and scanner FSM state type.
// Holds the segment width, the "all segments off" pattern, segment bit
// positions inside one digit byte, and the IDLE/BLANK/DRIVE state enum.
package disp_pkg;
    localparam int SEG_W = 8;
    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_DP = 7;
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
endpackage

// File: rtl/anode_scanner_if.sv
// anode_scanner_if: display-data side and pin side of the anode scanner.
// master drives en/digit_en/seg_in and observes the pins; slave is the
// scanner, producing an_n (active-low anodes), seg_n (active-low segments),
// sel (slot index) and frame_tick (end-of-frame pulse).
interface anode_scanner_if #(
    parameter int N_DIGITS = 4
);
    import disp_pkg::*;
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    logic                      en;
    logic [N_DIGITS-1:0]       digit_en;
    logic [N_DIGITS*SEG_W-1:0] seg_in;
    logic [N_DIGITS-1:0]       an_n;
    logic [SEG_W-1:0]          seg_n;
    logic [SEL_W-1:0]          sel;
    logic                      frame_tick;
    modport master (
        output en, digit_en, seg_in,
        input  an_n, seg_n, sel, frame_tick
    );
    modport slave (
        input  en, digit_en, seg_in,
        output an_n, seg_n, sel, frame_tick
    );
endinterface

// File: rtl/onehot_n_dec.sv
// onehot_n_dec: active-low binary to one-hot decoder with blanking.
// Ports: idx (binary select), blank (forces all outputs high),
// y_n (active-low one-hot of idx, or all ones when blanked).
module onehot_n_dec #(
    parameter int SEL_W    = 2,
    parameter int N_DIGITS = 4
) (
    input  logic [SEL_W-1:0]    idx,
    input  logic                blank,
    output logic [N_DIGITS-1:0] y_n
);
    always_comb y_n = blank ? '1 : ~(N_DIGITS'(1) << idx);
endmodule

// File: rtl/anode_scanner.sv
// anode_scanner: time-multiplexed common-anode seven-segment scanner.
// Ports: clk, rst (sync, active-high), bus (anode_scanner_if.slave):
// en/digit_en/seg_in in, registered an_n/seg_n/sel/frame_tick out.
// A prescaler (cnt) times each digit slot; the first BLANK_CYCLES of every
// slot keep all anodes off to suppress ghosting.
module anode_scanner
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rst,
    anode_scanner_if.slave bus
);
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] SLOT_MAX = SEL_W'(N_DIGITS - 1);

    scan_state_t       state, state_nx, cur;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [SEL_W-1:0]  slot, slot_nx;
    logic              wrap, lit;
    logic [SEG_W-1:0]  seg_sel;
    logic [N_DIGITS-1:0] an_dec;

    // state tracks the phase of the current cnt; IDLE means cnt was just
    // reset to 0, so its phase is the one a fresh slot starts in.
    always_comb begin
        cur      = (state == IDLE) ? ((BLANK_CYCLES > 0) ? BLANK : DRIVE) : state;
        wrap     = cnt == CNT_MAX;
        cnt_nx   = wrap ? '0 : cnt + 1'b1;
        slot_nx  = wrap ? ((slot == SLOT_MAX) ? '0 : slot + 1'b1) : slot;
        state_nx = !bus.en ? IDLE : ((int'(cnt_nx) < BLANK_CYCLES) ? BLANK : DRIVE);
        lit      = (cur == DRIVE) && bus.digit_en[slot];
        seg_sel  = bus.seg_in[SEG_W*slot +: SEG_W];
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    onehot_n_dec #(.SEL_W(SEL_W), .N_DIGITS(N_DIGITS)) u_dec (
        .idx  (slot),
        .blank(!lit),
        .y_n  (an_dec)
    );

    // Outputs are registered from this cycle's (cnt, slot, inputs).
    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            cnt            <= '0;
            slot           <= '0;
            bus.an_n       <= '1;
            bus.seg_n      <= SEG_OFF;
            bus.sel        <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            cnt            <= cnt_nx;
            slot           <= slot_nx;
            bus.an_n       <= an_dec;
            bus.seg_n      <= lit ? ~seg_sel : SEG_OFF;
            bus.sel        <= slot;
            bus.frame_tick <= wrap && (slot == SLOT_MAX);
        end
    end
endmodule

// File: tb/tb_anode_scanner.sv
// tb_anode_scanner: self-checking bench for anode_scanner (4-digit and 1-digit builds).
module tb_anode_scanner;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   t4 = 0;
    int   t1 = 0;

    always #5 clk = ~clk;

    anode_scanner_if #(.N_DIGITS(4)) i4();
    anode_scanner_if #(.N_DIGITS(1)) i1();

    anode_scanner #(.N_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) d4 (
        .clk(clk), .rst(rst), .bus(i4)
    );
    anode_scanner #(.N_DIGITS(1), .PRESCALE(4), .BLANK_CYCLES(0)) d1 (
        .clk(clk), .rst(rst), .bus(i1)
    );

    localparam logic [72:0] DARK = {1'b0, 32'd0, 8'hFF, 32'hFFFFFFFF};

    // Expected pins after the t-th enabled edge since the scan (re)started.
    function automatic logic [72:0] ref_out(int n, int p, int b, logic [31:0] de,
                                            logic [255:0] si, int t);
        int c, s;
        logic lit;
        logic [7:0] sg;
        c   = t % p;
        s   = (t / p) % n;
        lit = (c >= b) && de[s];
        sg  = si[8*s +: 8];
        return {(t % (n*p)) == n*p - 1, 32'(s), lit ? ~sg : 8'hFF,
                lit ? ~(32'd1 << s) : 32'hFFFFFFFF};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [72:0] e0, e1;
        @(posedge clk);
        e0 = (rst || !i4.en) ? DARK
           : ref_out(4, 8, 2, 32'(i4.digit_en), 256'(i4.seg_in), t4);
        e1 = (rst || !i1.en) ? DARK
           : ref_out(1, 4, 0, 32'(i1.digit_en), 256'(i1.seg_in), t1);
        t4 = (rst || !i4.en) ? 0 : t4 + 1;
        t1 = (rst || !i1.en) ? 0 : t1 + 1;
        #1;
        chk("an4",   32'(i4.an_n),       32'(e0[3:0]));
        chk("seg4",  32'(i4.seg_n),      32'(e0[39:32]));
        chk("sel4",  32'(i4.sel),        32'(e0[41:40]));
        chk("tick4", 32'(i4.frame_tick), 32'(e0[72]));
        chk("an1",   32'(i1.an_n),       32'(e1[0]));
        chk("seg1",  32'(i1.seg_n),      32'(e1[39:32]));
        chk("sel1",  32'(i1.sel),        32'(e1[40]));
        chk("tick1", 32'(i1.frame_tick), 32'(e1[72]));
    endtask

    initial begin
        int n4, n1, guard;
        rst = 1'b1;
        i4.en = 1'b1; i4.digit_en = 4'hF; i4.seg_in = 32'h4F5B0633;
        i1.en = 1'b1; i1.digit_en = 1'b1; i1.seg_in = 8'h06;
        repeat (3) step();
        chk("rst_an4", 32'(i4.an_n), 32'hF);
        chk("rst_seg4", 32'(i4.seg_n), 32'hFF);
        rst = 1'b0;

        n4 = 0; n1 = 0;
        for (int i = 0; i < 96; i++) begin
            step();
            if (i == 2) chk("lit0_seg", 32'(i4.seg_n), 32'hCC);
            if (i == 10) chk("lit1_seg", 32'(i4.seg_n), 32'hF9);
            n4 += int'(i4.frame_tick);
            n1 += int'(i1.frame_tick);
        end
        chk("ticks4", 32'(n4), 32'd3);
        chk("ticks1", 32'(n1), 32'd24);

        i4.digit_en = 4'b1010;
        repeat (32) step();
        i4.digit_en = 4'hF;

        for (int i = 0; i < 200; i++) begin
            if (i % 8 == 0) i4.digit_en = 4'($urandom_range(0, 15));
            i4.seg_in = $urandom;
            i1.seg_in = 8'($urandom);
            i1.digit_en = 1'($urandom_range(0, 7) != 0);
            step();
        end
        i4.digit_en = 4'hF; i4.seg_in = 32'h4F5B0633; i1.digit_en = 1'b1;

        guard = 0;
        while (t4 % 32 != 20 && guard < 64) begin step(); guard++; end
        chk("reach_slot2", 32'(t4 % 32), 32'd20);
        i4.en = 1'b0;
        step();
        chk("drop_dark_an", 32'(i4.an_n), 32'hF);
        chk("drop_dark_seg", 32'(i4.seg_n), 32'hFF);
        repeat (4) step();
        i4.en = 1'b1;
        step(); chk("restart_b0", 32'(i4.an_n), 32'hF);
        step(); chk("restart_b1", 32'(i4.an_n), 32'hF);
        step(); chk("restart_d0", 32'(i4.an_n), 32'hE);
        repeat (10) step();

        guard = 0;
        while (t4 % 32 != 28 && guard < 64) begin step(); guard++; end
        chk("reach_slot3", 32'(t4 % 32), 32'd28);
        rst = 1'b1;
        step();
        chk("mrst_an", 32'(i4.an_n), 32'hF);
        chk("mrst_seg", 32'(i4.seg_n), 32'hFF);
        chk("mrst_sel", 32'(i4.sel), 32'd0);
        chk("mrst_tick", 32'(i4.frame_tick), 32'd0);
        rst = 1'b0;
        repeat (40) step();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) i4.en = ~i4.en;
            if ($urandom_range(0, 31) == 0) i1.en = ~i1.en;
            rst = ($urandom_range(0, 63) == 0);
            i4.seg_in = $urandom;
            i4.digit_en = 4'($urandom_range(0, 15));
            i1.seg_in = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
